decoder_req_scheduler: RTL and testbench
========================================

Name: decoder_req_scheduler

Overview:
- Shares one decoder_proj decoder instance (7-bit code input, combinational or fixed-latency output) among NREQ requesters.
- Round-robin arbiter: grants one request at a time and latches the granted 7-bit code onto the decoder input.
- Holds the code for DEC_LAT cycles, samples the decoder output, and returns it on a single response channel tagged with the requester ID.
- Sits between the user-project I/O request logic and the decoder core.

Parameters:
- NREQ, 4, number of requesters (2..8).
- OUT_W, 16, decoder output width.
- DEC_LAT, 1, cycles dec_in is held before dec_out is sampled (>=1).
- IDLE_CODE, 7'h00, value driven on dec_in when no request is in flight.

Ports:
- clock  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_code  in  7*NREQ  per-requester code; requester i uses bits [7*i+6:7*i].
- req_ready  out  NREQ  one-hot grant/accept, combinational.
- dec_in  out  7  registered code driven to decoder io_in.
- dec_out  in  OUT_W  decoder result.
- rsp_valid  out  1  response valid.
- rsp_id  out  clog2(NREQ)  requester index of the response.
- rsp_data  out  OUT_W  sampled decoder result.
- rsp_ready  in  1  response consumer ready.
- busy  out  1  high when state != IDLE.

Behaviour:
- Reset (async assert, sync deassert by the integrator):
  - state=IDLE, rr_ptr=0, dec_in=IDLE_CODE.
  - rsp_valid=0, rsp_id=0, rsp_data=0, busy=0, hold counter=0.
  - Reset mid-transaction abandons it silently; no response is issued.
- FSM: IDLE -> DRIVE -> RESP -> IDLE.
- IDLE:
  - Grant the first asserted req_valid searching from rr_ptr upward, modulo NREQ.
  - req_ready is one-hot for the granted index and zero in all other states; the handshake is req_valid&req_ready.
  - On grant: dec_in<=granted code, rsp_id<=index, rr_ptr<=(index+1) mod NREQ, cnt<=DEC_LAT-1, go to DRIVE.
  - No request: stay in IDLE; dec_in stays IDLE_CODE.
- DRIVE:
  - dec_in held stable.
  - When cnt==0: rsp_data<=dec_out, rsp_valid<=1, go to RESP. Otherwise cnt decrements.
- RESP:
  - rsp_valid, rsp_id and rsp_data held stable until rsp_ready.
  - On rsp_valid&rsp_ready: rsp_valid<=0, dec_in<=IDLE_CODE, go to IDLE.
  - Back-pressure is unbounded; no timeout.
- Latency:
  - Request accepted in cycle t gives rsp_valid high from cycle t+DEC_LAT+1.
  - With rsp_ready held high, the next grant is possible at t+DEC_LAT+2, i.e. the cycle after the response handshake.
  - Throughput is one transaction per DEC_LAT+2 cycles.
- Arbitration rules:
  - req_valid/req_code may change freely while not granted; only the grant-cycle code is used.
  - Simultaneous requests are served in round-robin order.
  - A requester that keeps req_valid asserted waits at most NREQ-1 other grants.
  - A requester is never granted twice in a row while another is pending.
- Pointer wrap: after a grant to index NREQ-1, rr_ptr=0.
- busy=(state!=IDLE), registered state decode.

Test Plan:
- Single request: reset, requester 2 asserts req_valid with code 7'b1011001 (0x59), DEC_LAT=1, decoder model returns {9'h0,code}.
  -> req_ready=4'b0100 in the grant cycle; dec_in=0x59 next cycle; rsp_valid 2 cycles after the grant with rsp_id=2, rsp_data=16'h0059; dec_in returns to 0x00 after rsp_ready.
- All four requesting continuously with codes 0x10,0x11,0x12,0x13 -> grant order 0,1,2,3,0; rsp_data matches each code in that order.
- Back-pressure: rsp_ready=0 for 10 cycles after rsp_valid rises.
  -> rsp_valid/rsp_id/rsp_data stable; req_ready=0 for all requesters; busy=1 throughout.
- DEC_LAT=3: code 0x7F accepted at t.
  -> dec_in=0x7F from t+1 through t+3; rsp_valid at t+4; rsp_data equals dec_out sampled at t+3.
- Async reset asserted in DRIVE.
  -> outputs take reset values immediately; no rsp_valid after deassert; next grant starts from requester 0.
- Pointer wrap: only requesters 3 and 0 request -> grants alternate 3,0,3.

Source files
------------

// File: rtl/decoder_req_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : decoder_req_scheduler
// Description : Round-robin scheduler sharing one 7-bit-code decoder among
//               NREQ requesters, returning tagged results on one channel.
// Revision    : 1.0 - initial release
// ============================================================================
module decoder_req_scheduler #(
    parameter int         NREQ      = 4,
    parameter int         OUT_W     = 16,
    parameter int         DEC_LAT   = 1,
    parameter logic [6:0] IDLE_CODE = 7'h00
) (
    input  logic                    clock,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [7*NREQ-1:0]       req_code,
    output logic [NREQ-1:0]         req_ready,
    output logic [6:0]              dec_in,
    input  logic [OUT_W-1:0]        dec_out,
    output logic                    rsp_valid,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [OUT_W-1:0]        rsp_data,
    input  logic                    rsp_ready,
    output logic                    busy
);

    localparam int                  c_id_w     = $clog2(NREQ);
    localparam int                  c_cnt_w    = (DEC_LAT > 1) ? $clog2(DEC_LAT) : 1;
    localparam logic [c_id_w-1:0]   c_last_id  = c_id_w'(NREQ - 1);
    localparam logic [c_id_w:0]     c_nreq     = (c_id_w + 1)'(NREQ);
    localparam logic [c_cnt_w-1:0]  c_cnt_init = c_cnt_w'(DEC_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [c_id_w-1:0]   r_rr_ptr;
    logic [6:0]          r_dec_in;
    logic                r_rsp_valid;
    logic [c_id_w-1:0]   r_rsp_id;
    logic [OUT_W-1:0]    r_rsp_data;
    logic [c_cnt_w-1:0]  r_cnt;

    logic                w_grant_vld;
    logic [c_id_w-1:0]   w_grant_idx;
    logic [6:0]          w_grant_code;

    // Rotating search: candidate k is (rr_ptr + k) mod NREQ, first hit wins.
    always_comb begin : p_arb
        logic [c_id_w:0] w_cand;
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        w_cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_cand = {1'b0, r_rr_ptr} + (c_id_w + 1)'(k);
            if (w_cand >= c_nreq) begin
                w_cand = w_cand - c_nreq;
            end
            if ((r_state == S_IDLE) && !w_grant_vld && req_valid[w_cand[c_id_w-1:0]]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = w_cand[c_id_w-1:0];
            end
        end
    end

    always_comb begin : p_code_mux
        w_grant_code = req_code[6:0];
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant_idx == c_id_w'(i)) begin
                w_grant_code = req_code[7*i +: 7];
            end
        end
    end

    assign req_ready = w_grant_vld ? ({{(NREQ-1){1'b0}}, 1'b1} << w_grant_idx) : '0;

    always_ff @(posedge clock or negedge rst_n) begin : p_state_reg
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin : p_next_state
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_grant_vld)    w_state_next = S_DRIVE;
            S_DRIVE: if (r_cnt == '0)    w_state_next = S_RESP;
            S_RESP:  if (rsp_ready)      w_state_next = S_IDLE;
            default:                     w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin : p_datapath
        if (!rst_n) begin
            r_rr_ptr    <= '0;
            r_dec_in    <= IDLE_CODE;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_vld) begin
                        r_dec_in <= w_grant_code;
                        r_rsp_id <= w_grant_idx;
                        r_rr_ptr <= (w_grant_idx == c_last_id) ? '0 : w_grant_idx + 1'b1;
                        r_cnt    <= c_cnt_init;
                    end
                end
                S_DRIVE: begin
                    // Decoder has seen a stable code for DEC_LAT cycles once cnt hits zero.
                    if (r_cnt == '0) begin
                        r_rsp_data  <= dec_out;
                        r_rsp_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_dec_in    <= IDLE_CODE;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_dec_in    <= IDLE_CODE;
                end
            endcase
        end
    end

    assign dec_in    = r_dec_in;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;
    assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_decoder_req_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_decoder_req_scheduler
// Description : Bench for decoder_req_scheduler; two instances (DEC_LAT 1, 3)
//               share stimulus and are compared against a transaction model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decoder_req_scheduler;

    localparam int c_lat [2] = '{1, 3};

    logic        clock;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [27:0] req_code;
    logic        rsp_ready;

    logic [3:0]  req_ready_a, req_ready_b;
    logic [6:0]  dec_in_a, dec_in_b;
    logic [15:0] dec_out_a, dec_out_b;
    logic        rsp_valid_a, rsp_valid_b;
    logic [1:0]  rsp_id_a, rsp_id_b;
    logic [15:0] rsp_data_a, rsp_data_b;
    logic        busy_a, busy_b;

    logic [6:0]  r_p1 = '0;
    logic [6:0]  r_p2 = '0;

    int n_checks = 0;
    int n_errors = 0;

    // model state per instance
    bit         m_act  [2] = '{0, 0};
    int         m_age  [2] = '{0, 0};
    int         m_id   [2] = '{0, 0};
    int         m_ptr  [2] = '{0, 0};
    logic [6:0] m_code [2] = '{7'h0, 7'h0};

    decoder_req_scheduler #(.NREQ(4), .OUT_W(16), .DEC_LAT(1), .IDLE_CODE(7'h00)) u_dut_a (
        .clock     (clock),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_code  (req_code),
        .req_ready (req_ready_a),
        .dec_in    (dec_in_a),
        .dec_out   (dec_out_a),
        .rsp_valid (rsp_valid_a),
        .rsp_id    (rsp_id_a),
        .rsp_data  (rsp_data_a),
        .rsp_ready (rsp_ready),
        .busy      (busy_a)
    );

    decoder_req_scheduler #(.NREQ(4), .OUT_W(16), .DEC_LAT(3), .IDLE_CODE(7'h00)) u_dut_b (
        .clock     (clock),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_code  (req_code),
        .req_ready (req_ready_b),
        .dec_in    (dec_in_b),
        .dec_out   (dec_out_b),
        .rsp_valid (rsp_valid_b),
        .rsp_id    (rsp_id_b),
        .rsp_data  (rsp_data_b),
        .rsp_ready (rsp_ready),
        .busy      (busy_b)
    );

    // Decoder A is combinational; decoder B only shows a code two cycles after it is applied.
    assign dec_out_a = {9'h000, dec_in_a};
    always @(posedge clock) begin
        r_p1 <= dec_in_b;
        r_p2 <= r_p1;
    end
    assign dec_out_b = {2'b10, r_p2, r_p2};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [15:0] dec_f(input int inst, input logic [6:0] c);
        return (inst == 0) ? {9'h000, c} : {2'b10, c, c};
    endfunction

    function automatic int winner(input int ptr, input logic [3:0] v);
        for (int k = 0; k < 4; k++) begin
            int j;
            j = (ptr + k) % 4;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    task automatic check(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s inst%0d: got 0x%0h expected 0x%0h at %0t", name, inst, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Transaction model: a grant opens a transaction; response is due L+1 cycles later.
    always @(posedge clock or negedge rst_n) begin
        int         w;
        logic [27:0] sh;
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_act[i] <= 1'b0;
                m_ptr[i] <= 0;
                m_age[i] <= 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!m_act[i]) begin
                    w = winner(m_ptr[i], req_valid);
                    if (w >= 0) begin
                        sh = req_code >> (7 * w);
                        m_act[i]  <= 1'b1;
                        m_id[i]   <= w;
                        m_code[i] <= sh[6:0];
                        m_age[i]  <= 1;
                        m_ptr[i]  <= (w + 1) % 4;
                    end
                end else if (m_age[i] >= c_lat[i] + 1 && rsp_ready) begin
                    m_act[i] <= 1'b0;
                end else begin
                    m_age[i] <= m_age[i] + 1;
                end
            end
        end
    end

    always @(negedge clock) begin
        logic [3:0]  rr;
        logic [6:0]  di;
        logic        rv;
        logic [1:0]  ri;
        logic [15:0] rd;
        logic        bz;
        logic [3:0]  er;
        bit          ev;
        int          w;
        for (int i = 0; i < 2; i++) begin
            rr = (i == 0) ? req_ready_a : req_ready_b;
            di = (i == 0) ? dec_in_a    : dec_in_b;
            rv = (i == 0) ? rsp_valid_a : rsp_valid_b;
            ri = (i == 0) ? rsp_id_a    : rsp_id_b;
            rd = (i == 0) ? rsp_data_a  : rsp_data_b;
            bz = (i == 0) ? busy_a      : busy_b;
            w  = winner(m_ptr[i], req_valid);
            er = (!m_act[i] && w >= 0) ? 4'(1 << w) : 4'b0000;
            ev = m_act[i] && (m_age[i] >= c_lat[i] + 1);
            check("req_ready", i, 32'(rr), 32'(er));
            check("dec_in",    i, 32'(di), m_act[i] ? 32'(m_code[i]) : 32'h0);
            check("rsp_valid", i, 32'(rv), 32'(ev));
            check("busy",      i, 32'(bz), 32'(m_act[i]));
            if (ev) begin
                check("rsp_id",   i, 32'(ri), 32'(m_id[i]));
                check("rsp_data", i, 32'(rd), 32'(dec_f(i, m_code[i])));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          got;
        logic [1:0]  ids [5];
        logic [15:0] dat [5];
        logic [15:0] samp;
        int          exp_ids [5] = '{0, 1, 2, 3, 0};
        logic [15:0] exp_dat [5] = '{16'h10, 16'h11, 16'h12, 16'h13, 16'h10};
        int          wr_ids  [3] = '{3, 0, 3};
        logic [15:0] wr_dat  [3] = '{16'h33, 16'h30, 16'h33};

        for (int k = 0; k < 5; k++) begin
            ids[k] = '0;
            dat[k] = '0;
        end
        rst_n = 1'b0; req_valid = '0; req_code = '0; rsp_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("rst_dec_in",    0, 32'(dec_in_a),    32'h0);
        check("rst_rsp_valid", 0, 32'(rsp_valid_a), 32'h0);
        check("rst_rsp_id",    0, 32'(rsp_id_a),    32'h0);
        check("rst_rsp_data",  0, 32'(rsp_data_a),  32'h0);
        check("rst_busy",      0, 32'(busy_a),      32'h0);
        rst_n = 1'b1;
        cyc(); cyc();

        // all four requesting continuously
        req_code  = {7'h13, 7'h12, 7'h11, 7'h10};
        req_valid = 4'b1111;
        got = 0;
        for (int c = 0; c < 60 && got < 5; c++) begin
            cyc();
            if (rsp_valid_a && rsp_ready) begin
                ids[got] = rsp_id_a;
                dat[got] = rsp_data_a;
                got++;
            end
        end
        req_valid = '0;
        check("rr_count", 0, 32'(got), 32'd5);
        for (int k = 0; k < 5; k++) begin
            check("rr_order", 0, 32'(ids[k]), 32'(exp_ids[k]));
            check("rr_data",  0, 32'(dat[k]), 32'(exp_dat[k]));
        end
        repeat (10) cyc();

        // single request from requester 2
        req_code = '0;
        req_code[20:14] = 7'h59;
        req_valid = 4'b0100;
        #1;
        check("single_ready", 0, 32'(req_ready_a), 32'h4);
        check("single_ready", 1, 32'(req_ready_b), 32'h4);
        cyc();
        req_valid = '0;
        check("single_dec_in",  0, 32'(dec_in_a),    32'h59);
        check("single_busy",    0, 32'(busy_a),      32'h1);
        check("single_early",   0, 32'(rsp_valid_a), 32'h0);
        cyc();
        check("single_valid",   0, 32'(rsp_valid_a), 32'h1);
        check("single_id",      0, 32'(rsp_id_a),    32'h2);
        check("single_data",    0, 32'(rsp_data_a),  32'h0059);
        check("single_dec_in",  1, 32'(dec_in_b),    32'h59);
        cyc();
        check("single_idle_in", 0, 32'(dec_in_a),    32'h0);
        check("single_done",    0, 32'(rsp_valid_a), 32'h0);
        check("single_early",   1, 32'(rsp_valid_b), 32'h0);
        cyc();
        check("single_valid",   1, 32'(rsp_valid_b), 32'h1);
        check("single_id",      1, 32'(rsp_id_b),    32'h2);
        check("single_data",    1, 32'(rsp_data_b),  32'hACD9);
        cyc();
        check("single_idle_in", 1, 32'(dec_in_b),    32'h0);
        repeat (3) cyc();

        // back-pressure with other requesters waiting
        rsp_ready = 1'b0;
        req_code  = '0;
        req_code[13:7] = 7'h2A;
        req_valid = 4'b0010;
        got = 0;
        for (int c = 0; c < 10 && got == 0; c++) begin
            cyc();
            if (rsp_valid_a) got = 1;
        end
        check("bp_wait", 0, 32'(got), 32'd1);
        req_valid = 4'b1111;
        req_code  = {7'h43, 7'h42, 7'h41, 7'h40};
        for (int k = 0; k < 10; k++) begin
            #1;
            check("bp_valid", 0, 32'(rsp_valid_a), 32'h1);
            check("bp_id",    0, 32'(rsp_id_a),    32'h1);
            check("bp_data",  0, 32'(rsp_data_a),  32'h002A);
            check("bp_ready", 0, 32'(req_ready_a), 32'h0);
            check("bp_busy",  0, 32'(busy_a),      32'h1);
            cyc();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (8) cyc();

        // DEC_LAT=3 timing on instance B
        req_code = '0;
        req_code[27:21] = 7'h7F;
        req_valid = 4'b1000;
        #1;
        check("lat3_ready", 1, 32'(req_ready_b), 32'h8);
        cyc();
        req_valid = '0;
        check("lat3_dec_t1", 1, 32'(dec_in_b),    32'h7F);
        check("lat3_v_t1",   1, 32'(rsp_valid_b), 32'h0);
        cyc();
        check("lat3_dec_t2", 1, 32'(dec_in_b),    32'h7F);
        check("lat3_v_t2",   1, 32'(rsp_valid_b), 32'h0);
        cyc();
        check("lat3_dec_t3", 1, 32'(dec_in_b),    32'h7F);
        check("lat3_v_t3",   1, 32'(rsp_valid_b), 32'h0);
        samp = dec_out_b;
        cyc();
        check("lat3_v_t4",   1, 32'(rsp_valid_b), 32'h1);
        check("lat3_sample", 1, 32'(rsp_data_b),  32'(samp));
        check("lat3_data",   1, 32'(rsp_data_b),  32'hBFFF);
        cyc();
        check("lat3_idle",   1, 32'(dec_in_b),    32'h0);
        check("lat3_busy",   1, 32'(busy_b),      32'h0);
        repeat (3) cyc();

        // pointer wrap: park pointer at 3, then 3 and 0 compete
        req_code = '0;
        req_code[20:14] = 7'h22;
        req_valid = 4'b0100;
        cyc();
        req_valid = '0;
        repeat (6) cyc();
        req_code  = {7'h33, 7'h00, 7'h00, 7'h30};
        req_valid = 4'b1001;
        got = 0;
        for (int c = 0; c < 40 && got < 3; c++) begin
            cyc();
            if (rsp_valid_a && rsp_ready) begin
                ids[got] = rsp_id_a;
                dat[got] = rsp_data_a;
                got++;
            end
        end
        req_valid = '0;
        check("wrap_count", 0, 32'(got), 32'd3);
        for (int k = 0; k < 3; k++) begin
            check("wrap_order", 0, 32'(ids[k]), 32'(wr_ids[k]));
            check("wrap_data",  0, 32'(dat[k]), 32'(wr_dat[k]));
        end
        repeat (10) cyc();

        // async reset while in DRIVE
        req_code = '0;
        req_code[13:7] = 7'h21;
        req_valid = 4'b0010;
        cyc();
        req_valid = '0;
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_dec_in",    0, 32'(dec_in_a),    32'h0);
        check("arst_busy",      0, 32'(busy_a),      32'h0);
        check("arst_rsp_valid", 0, 32'(rsp_valid_a), 32'h0);
        check("arst_rsp_id",    0, 32'(rsp_id_a),    32'h0);
        check("arst_rsp_data",  0, 32'(rsp_data_a),  32'h0);
        check("arst_dec_in",    1, 32'(dec_in_b),    32'h0);
        check("arst_busy",      1, 32'(busy_b),      32'h0);
        repeat (2) @(posedge clock);
        #1;
        rst_n = 1'b1;
        repeat (4) cyc();
        req_code  = {7'h04, 7'h03, 7'h02, 7'h01};
        req_valid = 4'b1111;
        #1;
        check("arst_ptr", 0, 32'(req_ready_a), 32'h1);
        check("arst_ptr", 1, 32'(req_ready_b), 32'h1);
        cyc();
        req_valid = '0;
        repeat (8) cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
